timer_arbiter: RTL and testbench

TIMER_ARBITER -- requirements
Module: timer_arbiter

---
 rtl/timer_arbiter_if.sv | 26 ++
 rtl/timer_arbiter.sv | 117 +++++++++++
 tb/tb_timer_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/timer_arbiter_if.sv
// Bundle between requesters, the round-robin timer arbiter and one shared flex counter.
// The slave side is the arbiter; the master side is the requesters plus the counter.
interface timer_arbiter_if #(
    parameter int NUM_REQ  = 4,
    parameter int CNT_BITS = 16
);
    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ*CNT_BITS-1:0] dur;
    logic [NUM_REQ-1:0]          grant;
    logic [NUM_REQ-1:0]          done;
    logic                        busy;
    logic                        cnt_clear;
    logic                        cnt_enable;
    logic [CNT_BITS-1:0]         cnt_rollover_val;
    logic                        cnt_rollover_flag;

    modport slave (
        input  req, dur, cnt_rollover_flag,
        output grant, done, busy, cnt_clear, cnt_enable, cnt_rollover_val
    );

    modport master (
        output req, dur, cnt_rollover_flag,
        input  grant, done, busy, cnt_clear, cnt_enable, cnt_rollover_val
    );
endinterface

// File: rtl/timer_arbiter.sv
// Round-robin arbiter that lends one shared flex counter to NUM_REQ requesters,
// timing each owner's interval and pulsing done when the counter reaches it.
module timer_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int CNT_BITS = 16
) (
    input  logic          clk,
    input  logic          rst,
    timer_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t              state_reg, state_next;
    logic [IDX_W-1:0]    idx_reg, idx_next;
    logic [IDX_W-1:0]    ptr_reg, ptr_next;
    logic [CNT_BITS-1:0] dur_reg, dur_next;

    logic [CNT_BITS-1:0] dur_arr [NUM_REQ];
    logic [IDX_W-1:0]    sel_idx;
    logic [IDX_W-1:0]    cand_idx;
    logic [IDX_W-1:0]    idx_inc;
    logic                sel_found;
    logic                owner_req;
    logic                owned;
    int                  cand;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign dur_arr[gi]   = bus.dur[gi*CNT_BITS +: CNT_BITS];
            assign bus.grant[gi] = owned && (idx_reg == IDX_W'(gi));
            assign bus.done[gi]  = (state_reg == DONE) && (idx_reg == IDX_W'(gi));
        end
    endgenerate

    // First pending requester at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr_reg) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!sel_found && bus.req[cand_idx]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx;
            end
        end
    end

    assign idx_inc   = (idx_reg == IDX_W'(NUM_REQ - 1)) ? '0 : idx_reg + 1'b1;
    assign owner_req = bus.req[idx_reg];
    assign owned     = (state_reg != IDLE);

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        ptr_next   = ptr_reg;
        dur_next   = dur_reg;
        case (state_reg)
            IDLE: begin
                if (sel_found) begin
                    idx_next   = sel_idx;
                    dur_next   = dur_arr[sel_idx];
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (!owner_req) begin
                    ptr_next   = idx_inc;
                    state_next = IDLE;
                end else if (dur_reg == '0) begin
                    state_next = DONE;
                end else begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!owner_req) begin
                    ptr_next   = idx_inc;
                    state_next = IDLE;
                end else if (bus.cnt_rollover_flag) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                ptr_next   = idx_inc;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // An abandoning owner also clears the counter so the next owner starts clean.
    assign bus.busy             = owned;
    assign bus.cnt_clear        = (state_reg == LOAD) || ((state_reg == RUN) && !owner_req);
    assign bus.cnt_enable       = (state_reg == RUN) && owner_req && !bus.cnt_rollover_flag;
    assign bus.cnt_rollover_val = dur_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            ptr_reg   <= '0;
            dur_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            ptr_reg   <= ptr_next;
            dur_reg   <= dur_next;
        end
    end
endmodule

// File: tb/tb_timer_arbiter.sv
// Bench for timer_arbiter: directed scenarios plus random traffic, checked every cycle
// against a timeline model of each grant (LOAD, dur counting cycles, flag cycle, DONE).
module tb_timer_arbiter;
    localparam int N  = 4;
    localparam int CB = 8;

    logic tb_clk = 1'b0;
    logic rst;

    timer_arbiter_if #(.NUM_REQ(N), .CNT_BITS(CB)) bus ();

    timer_arbiter #(.NUM_REQ(N), .CNT_BITS(CB)) dut (
        .clk (tb_clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 tb_clk = ~tb_clk;

    // Shared flex counter: wraps to 1 after reaching rollover_val, flag while equal.
    logic [CB-1:0] cnt;
    always_ff @(posedge tb_clk or posedge rst) begin
        if (rst)                 cnt <= '0;
        else if (bus.cnt_clear)  cnt <= '0;
        else if (bus.cnt_enable) cnt <= (cnt == bus.cnt_rollover_val) ? CB'(1) : cnt + 1'b1;
    end
    assign bus.cnt_rollover_flag = (cnt == bus.cnt_rollover_val);

    int checks   = 0;
    int failures = 0;

    int m_owner = -1;
    int m_age   = 0;
    int m_dur   = 0;
    int m_ptr   = 0;
    int evt_idx = -1;
    int dur_val [N];
    logic [N-1:0] hold_mask = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_dur(input int i, input int v);
        bus.dur[i*CB +: CB] = CB'(v);
        dur_val[i] = v;
    endtask

    function automatic int grant_len(input int d);
        return (d == 0) ? 2 : d + 3;
    endfunction

    function automatic bit req_bit(input int i);
        return ((bus.req >> i) & 1) != 0;
    endfunction

    task automatic check_outputs();
        logic [N-1:0] eg, ed;
        logic eb, ec, ee, ab;
        eg = '0; ed = '0; eb = 1'b0; ec = 1'b0; ee = 1'b0; ab = 1'b0;
        if (m_owner >= 0) begin
            ab = !req_bit(m_owner) && (m_age < grant_len(m_dur) - 1);
            eg = N'(1) << m_owner;
            eb = 1'b1;
            if (m_age == grant_len(m_dur) - 1) ed = eg;
            ec = (m_age == 0) || ab;
            ee = !ab && (m_age >= 1) && (m_age <= m_dur);
            check_eq("rollover_val", 32'(bus.cnt_rollover_val), 32'(m_dur));
        end else if (rst) begin
            check_eq("rollover_val_rst", 32'(bus.cnt_rollover_val), 32'd0);
        end
        check_eq("grant", 32'(bus.grant), 32'(eg));
        check_eq("done", 32'(bus.done), 32'(ed));
        check_eq("busy", 32'(bus.busy), 32'(eb));
        check_eq("cnt_clear", 32'(bus.cnt_clear), 32'(ec));
        check_eq("cnt_enable", 32'(bus.cnt_enable), 32'(ee));
    endtask

    task automatic model_edge();
        evt_idx = -1;
        if (rst) begin
            m_owner = -1;
            m_ptr   = 0;
        end else if (m_owner >= 0) begin
            if (m_age == grant_len(m_dur) - 1) begin
                $display("txn requester=%0d dur=%0d outcome=done", m_owner, m_dur);
                evt_idx = m_owner;
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end else if (!req_bit(m_owner)) begin
                $display("txn requester=%0d dur=%0d outcome=abandoned", m_owner, m_dur);
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end else begin
                m_age++;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (m_owner < 0 && req_bit((m_ptr + k) % N)) begin
                    m_owner = (m_ptr + k) % N;
                    m_dur   = dur_val[m_owner];
                    m_age   = 0;
                end
            end
        end
    endtask

    // One clock: check current outputs, take the edge, update the model, retire finished requests.
    task automatic step();
        #1;
        check_outputs();
        @(posedge tb_clk);
        model_edge();
        #2;
        if (evt_idx >= 0 && !hold_mask[evt_idx]) bus.req[evt_idx] = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst     = 1'b1;
        bus.req = '0;
        bus.dur = '0;
        for (int i = 0; i < N; i++) dur_val[i] = 0;
        steps(2);
        rst = 1'b0;
        steps(2);

        // Single request, dur 5
        set_dur(0, 5); bus.req = 4'b0001; steps(12);
        // Zero duration goes LOAD -> DONE
        set_dur(0, 0); bus.req = 4'b0001; steps(5);
        // All four held with dur 2: rotating service
        for (int i = 0; i < N; i++) set_dur(i, 2);
        hold_mask = 4'b1111; bus.req = 4'b1111; steps(26);
        bus.req = '0; hold_mask = '0; steps(3);
        // Abandon after 3 RUN cycles, pending req2 served next
        set_dur(1, 10); set_dur(2, 3); bus.req = 4'b0010; steps(5);
        bus.req = 4'b0100; steps(10);
        // Duration change during RUN must not affect the owner
        set_dur(1, 4); bus.req = 4'b0010; steps(4);
        set_dur(1, 9); steps(8);
        // Reset mid-RUN, then a fresh request
        set_dur(0, 25); bus.req = 4'b0001; steps(9);
        rst = 1'b1; m_owner = -1; m_ptr = 0;
        steps(2);
        set_dur(0, 3); rst = 1'b0; steps(9);
        // Full-scale duration
        set_dur(0, (1 << CB) - 1); bus.req = 4'b0001; steps(262);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            hold_mask = N'($urandom);
            for (int i = 0; i < N; i++) begin
                if (!req_bit(i) && ($urandom % 4) == 0) begin
                    set_dur(i, int'($urandom_range(0, 12)));
                    bus.req[i] = 1'b1;
                end else if (req_bit(i) && m_owner == i && ($urandom % 40) == 0) begin
                    bus.req[i] = 1'b0;
                end
                if (($urandom % 8) == 0) set_dur(i, int'($urandom_range(0, 20)));
            end
            step();
        end
        bus.req = '0;
        steps(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
